// File: rtl/lc3_decode_if.sv
// Decode-stage bus: fetch/controller side (master) drives the instruction,
// decode side (slave) returns the registered instruction and control bundles.
interface lc3_decode_if;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_control;
    logic [1:0]  W_control;
    logic        Mem_control;
    logic        illegal_op;

    modport master (
        output enable_decode, dout, npc_in,
        input  IR, npc_out, E_control, W_control, Mem_control, illegal_op
    );

    modport slave (
        input  enable_decode, dout, npc_in,
        output IR, npc_out, E_control, W_control, Mem_control, illegal_op
    );
endinterface

// File: rtl/lc3_decode.sv
// LC3 decode stage: decodes the fetched word combinationally and registers
// IR, npc and the execute/memory/writeback control bundles on enable_decode.
module lc3_decode (
    input  logic        clock,
    input  logic        reset,
    lc3_decode_if.slave dec
);
    typedef enum logic [3:0] {
        OP_BR   = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
    } opcode_e;

    opcode_e     op;
    logic [1:0]  alu_control;
    logic [1:0]  pcselect1;
    logic        pcselect2;
    logic        op2select;
    logic [1:0]  w_sel;
    logic        mem_ind;
    logic        illegal;

    always_comb begin
        op          = opcode_e'(dec.dout[15:12]);
        alu_control = '0;
        pcselect1   = '0;
        pcselect2   = 1'b0;
        op2select   = 1'b0;
        w_sel       = '0;
        mem_ind     = 1'b0;
        illegal     = 1'b0;
        case (op)
            OP_ADD: op2select = ~dec.dout[5];
            OP_AND: begin alu_control = 2'b01; op2select = ~dec.dout[5]; end
            OP_NOT: begin alu_control = 2'b10; op2select = 1'b1; end
            OP_BR:  begin pcselect1 = 2'b01; pcselect2 = 1'b1; end
            OP_LD:  begin pcselect1 = 2'b01; pcselect2 = 1'b1; w_sel = 2'b01; end
            OP_LDI: begin pcselect1 = 2'b01; pcselect2 = 1'b1; w_sel = 2'b01; mem_ind = 1'b1; end
            OP_ST:  begin pcselect1 = 2'b01; pcselect2 = 1'b1; end
            OP_STI: begin pcselect1 = 2'b01; pcselect2 = 1'b1; mem_ind = 1'b1; end
            OP_LEA: begin pcselect1 = 2'b01; pcselect2 = 1'b1; w_sel = 2'b10; end
            OP_LDR: begin pcselect1 = 2'b10; w_sel = 2'b01; end
            OP_STR: pcselect1 = 2'b10;
            OP_JMP: ;
            // RTI, JSR, reserved and TRAP: all control stays zero
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dec.IR          <= '0;
            dec.npc_out     <= '0;
            dec.E_control   <= '0;
            dec.W_control   <= '0;
            dec.Mem_control <= 1'b0;
            dec.illegal_op  <= 1'b0;
        end else if (dec.enable_decode) begin
            dec.IR          <= dec.dout;
            dec.npc_out     <= dec.npc_in;
            dec.E_control   <= {alu_control, pcselect1, pcselect2, op2select};
            dec.W_control   <= w_sel;
            dec.Mem_control <= mem_ind;
            dec.illegal_op  <= illegal;
        end
    end
endmodule

// File: tb/tb_lc3_decode.sv
// Directed self-checking bench for lc3_decode with hand-computed expectations.
module tb_lc3_decode;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    lc3_decode_if bus ();

    lc3_decode dut (
        .clock (clock),
        .reset (reset),
        .dec   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic [15:0] ir, input logic [15:0] npc,
                           input logic [5:0] e, input logic [1:0] w, input logic m,
                           input logic ill);
        check($sformatf("%s.IR", tag),      bus.IR,                 ir);
        check($sformatf("%s.npc", tag),     bus.npc_out,            npc);
        check($sformatf("%s.E", tag),       {10'd0, bus.E_control}, {10'd0, e});
        check($sformatf("%s.W", tag),       {14'd0, bus.W_control}, {14'd0, w});
        check($sformatf("%s.Mem", tag),     {15'd0, bus.Mem_control}, {15'd0, m});
        check($sformatf("%s.illegal", tag), {15'd0, bus.illegal_op},  {15'd0, ill});
    endtask

    // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic apply(input logic [15:0] d, input logic [15:0] n, input logic en);
        @(negedge clock);
        bus.dout          = d;
        bus.npc_in        = n;
        bus.enable_decode = en;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bus.enable_decode = 1'b1;
        bus.dout          = 16'h12A3;
        bus.npc_in        = 16'h3001;
        #12;
        exp_out("reset", 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0, 1'b0);
        // enable held high across an edge during reset: reset wins
        @(posedge clock); #1;
        exp_out("rst_en", 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;

        apply(16'h12A3, 16'h3001, 1'b1);
        exp_out("add_imm", 16'h12A3, 16'h3001, 6'b000000, 2'b00, 1'b0, 1'b0);

        for (int unsigned i = 0; i < 3; i++) begin
            apply(16'h5262, 16'h4000 + 16'(i), 1'b0);
            exp_out($sformatf("hold%0d", i), 16'h12A3, 16'h3001, 6'b000000, 2'b00, 1'b0, 1'b0);
        end
        apply(16'h5262, 16'h3002, 1'b1);
        exp_out("reenable", 16'h5262, 16'h3002, 6'b010000, 2'b00, 1'b0, 1'b0);

        vecs.push_back('{"add_reg", 16'h1282, 6'b000001, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"and_imm", 16'h5262, 6'b010000, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"and_reg", 16'h5242, 6'b010001, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"not",     16'h927F, 6'b100001, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"ldr",     16'h6705, 6'b001000, 2'b01, 1'b0, 1'b0});
        vecs.push_back('{"str",     16'h7705, 6'b001000, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"ldi",     16'hA1FF, 6'b000110, 2'b01, 1'b1, 1'b0});
        vecs.push_back('{"sti",     16'hB1FF, 6'b000110, 2'b00, 1'b1, 1'b0});
        vecs.push_back('{"ld",      16'h2005, 6'b000110, 2'b01, 1'b0, 1'b0});
        vecs.push_back('{"st",      16'h3005, 6'b000110, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"lea",     16'hE005, 6'b000110, 2'b10, 1'b0, 1'b0});
        vecs.push_back('{"br",      16'h0E05, 6'b000110, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"jmp",     16'hC1C0, 6'b000000, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"trap",    16'hF025, 6'b000000, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"add_after_trap", 16'h12A3, 6'b000000, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{"rti",     16'h8000, 6'b000000, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"jsr",     16'h4805, 6'b000000, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"reserved", 16'hD123, 6'b000000, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{"not_after_rsv", 16'h927F, 6'b100001, 2'b00, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            apply(vecs[i].instr, 16'h5000 + 16'(i), 1'b1);
            exp_out(vecs[i].name, vecs[i].instr, 16'h5000 + 16'(i),
                    vecs[i].e, vecs[i].w, vecs[i].m, vecs[i].ill);
        end

        // Asynchronous reset between edges
        apply(16'hA1FF, 16'h3003, 1'b1);
        exp_out("pre_rst", 16'hA1FF, 16'h3003, 6'b000110, 2'b01, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        exp_out("async_rst", 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        apply(16'h12A3, 16'h3001, 1'b1);
        exp_out("post_rst", 16'h12A3, 16'h3001, 6'b000000, 2'b00, 1'b0, 1'b0);

        // Back-to-back decode, no bubbles
        apply(16'h12A3, 16'h3001, 1'b1);
        exp_out("b2b0", 16'h12A3, 16'h3001, 6'b000000, 2'b00, 1'b0, 1'b0);
        apply(16'h6705, 16'h3002, 1'b1);
        exp_out("b2b1", 16'h6705, 16'h3002, 6'b001000, 2'b01, 1'b0, 1'b0);
        apply(16'hA1FF, 16'h3003, 1'b1);
        exp_out("b2b2", 16'hA1FF, 16'h3003, 6'b000110, 2'b01, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
